// File: rtl/params.sv
// Shared types and constants for the D-matrix write-back path.
package params;

  typedef enum logic [1:0] {
    TYPE_FP16 = 2'd0,
    TYPE_FP32 = 2'd1,
    TYPE_INT8 = 2'd2,
    TYPE_INT4 = 2'd3
  } type_t;

  typedef enum logic [1:0] {
    RC_M32N8   = 2'd0,
    RC_M16N16  = 2'd1,
    RC_M8N32   = 2'd2,
    RC_ILLEGAL = 2'd3
  } rc_t;

  localparam int TILES_PER_MAT = 4;
  localparam int BPT_FP16      = 4;
  localparam int BPT_WIDE      = 8;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_SEND = 2'd1,
    WB_WAIT = 2'd2
  } wb_state_t;

  // FP16 packs two rows per beat, every other type one row per beat.
  function automatic logic [3:0] beats_per_tile(type_t t);
    return (t == TYPE_FP16) ? 4'(BPT_FP16) : 4'(BPT_WIDE);
  endfunction

endpackage

// File: rtl/trans_d_wb_if.sv
// AXI write-data channel as seen by the D-matrix serializer.
interface trans_d_wb_if #(
  parameter int DW = 256
);
  logic          axi_wvalid;
  logic          axi_wready;
  logic [DW-1:0] axi_wdata;
  logic          axi_wlast;
  logic [5:0]    burst_num;

  modport master (
    output axi_wvalid, axi_wdata, axi_wlast, burst_num,
    input  axi_wready
  );

  modport slave (
    input  axi_wvalid, axi_wdata, axi_wlast, burst_num,
    output axi_wready
  );
endinterface

// File: rtl/trans_d_pack.sv
// Combinational beat packer: selects one 256-bit beat out of an 8x8 tile of accumulators.
module trans_d_pack
  import params::*;
#(
  parameter int DW = 256
) (
  input  logic [7:0][7:0][31:0] tile,
  input  type_t                 dtype,
  input  logic [2:0]            beat,
  output logic [DW-1:0]         beat_data
);

  logic [2:0] row_lo;
  logic [2:0] row_hi;

  assign row_lo = {beat[1:0], 1'b0};
  assign row_hi = {beat[1:0], 1'b1};

  // FP16 keeps only the low halfword of each accumulator, two rows per beat.
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (dtype == TYPE_FP16) begin
        beat_data[16*i     +: 16] = tile[row_lo][i][15:0];
        beat_data[16*(i+8) +: 16] = tile[row_hi][i][15:0];
      end else begin
        beat_data[32*i +: 32] = tile[beat][i];
      end
    end
  end

endmodule

// File: rtl/trans_d_wb.sv
// Write-back serializer: turns four 8x8 accumulator tiles into AXI write beats for one D matrix.
module trans_d_wb #(
  parameter int TILES_PER_MAT = params::TILES_PER_MAT,
  parameter int DW            = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tile_valid,
  output logic                  tile_ready,
  input  logic [7:0][7:0][31:0] tile_data,
  input  params::type_t         data_type,
  input  params::rc_t           rc,
  trans_d_wb_if.master          axi,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(TILES_PER_MAT);

  params::wb_state_t     state_q, state_n;
  logic [7:0][7:0][31:0] tile_q, pack_tile;
  params::type_t         type_q, pack_type;
  logic [CNT_W-1:0]      tile_cnt_q, tile_cnt_n;
  logic [2:0]            beat_q, beat_n;
  logic [3:0]            bpt_q, bpt_n;
  logic                  accept, first, illegal, hs, last_beat, last_tile;
  logic                  load, done_n, err_set, wlast_n;
  logic [5:0]            burst_n;
  logic [DW-1:0]         pack_data;
  logic [DW-1:0]         wdata_q;
  logic                  wvalid_q, wlast_q, done_q, err_q;
  logic [5:0]            burst_q;

  assign accept    = tile_valid && (state_q != params::WB_SEND);
  assign first     = accept && (state_q == params::WB_IDLE);
  assign illegal   = first && (rc == params::RC_ILLEGAL);
  assign pack_type = first ? data_type : type_q;
  assign pack_tile = accept ? tile_data : tile_q;
  assign bpt_q     = params::beats_per_tile(type_q);
  assign bpt_n     = params::beats_per_tile(pack_type);
  assign hs        = wvalid_q && axi.axi_wready;
  assign last_beat = ({1'b0, beat_q} == (bpt_q - 4'd1));
  assign last_tile = (tile_cnt_q == CNT_W'(TILES_PER_MAT - 1));

  always_comb begin
    state_n    = state_q;
    beat_n     = beat_q;
    tile_cnt_n = tile_cnt_q;
    load       = 1'b0;
    done_n     = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      params::WB_IDLE: begin
        if (accept) begin
          if (illegal) begin
            err_set = 1'b1;
          end else begin
            state_n    = params::WB_SEND;
            beat_n     = 3'd0;
            tile_cnt_n = '0;
            load       = 1'b1;
          end
        end
      end
      params::WB_WAIT: begin
        if (accept) begin
          state_n = params::WB_SEND;
          beat_n  = 3'd0;
          load    = 1'b1;
        end
      end
      params::WB_SEND: begin
        if (hs) begin
          if (!last_beat) begin
            beat_n = beat_q + 3'd1;
            load   = 1'b1;
          end else if (last_tile) begin
            state_n = params::WB_IDLE;
            done_n  = 1'b1;
          end else begin
            tile_cnt_n = tile_cnt_q + 1'b1;
            state_n    = params::WB_WAIT;
          end
        end
      end
      default: state_n = params::WB_IDLE;
    endcase
  end

  // Next beat is packed ahead of the edge so the output register holds it one cycle after acceptance.
  trans_d_pack #(.DW(DW)) u_pack (
    .tile      (pack_tile),
    .dtype     (pack_type),
    .beat      (beat_n),
    .beat_data (pack_data)
  );

  assign burst_n = 6'(tile_cnt_n) * 6'(bpt_n) + 6'(beat_n);
  assign wlast_n = (tile_cnt_n == CNT_W'(TILES_PER_MAT - 1)) &&
                   ({1'b0, beat_n} == (bpt_n - 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= params::WB_IDLE;
      beat_q     <= 3'd0;
      tile_cnt_q <= '0;
      type_q     <= params::TYPE_FP32;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      wdata_q    <= '0;
      burst_q    <= 6'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      beat_q     <= beat_n;
      tile_cnt_q <= tile_cnt_n;
      done_q     <= done_n;
      wvalid_q   <= (state_n == params::WB_SEND);
      if (err_set) err_q <= 1'b1;
      if (first && !illegal) type_q <= data_type;
      if (load) begin
        wdata_q <= pack_data;
        burst_q <= burst_n;
        wlast_q <= wlast_n;
      end else if (hs) begin
        wlast_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !illegal) tile_q <= tile_data;
  end

  assign tile_ready     = (state_q != params::WB_SEND);
  assign axi.axi_wvalid = wvalid_q;
  assign axi.axi_wdata  = wdata_q;
  assign axi.axi_wlast  = wlast_q;
  assign axi.burst_num  = burst_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_trans_d_wb.sv
// Bench for trans_d_wb: directed matrices checked against a queue-based beat model.
module tb_trans_d_wb;
  import params::*;

  typedef logic [7:0][7:0][31:0] tile_t;
  typedef struct packed {
    logic [255:0] data;
    logic [5:0]   burst;
    logic         last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  tile_valid;
  logic  tile_ready;
  tile_t tile_data;
  type_t data_type;
  rc_t   rc;
  logic  done;
  logic  err;

  trans_d_wb_if #(.DW(256)) axi_if ();

  trans_d_wb #(.TILES_PER_MAT(4), .DW(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_data  (tile_data),
    .data_type  (data_type),
    .rc         (rc),
    .axi        (axi_if),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t        exp_q[$];
  int           mdl_idx;
  bit           chk_en = 1'b0;
  bit           rmode  = 1'b0;
  logic [3:0]   rpat   = 4'b1001;
  int           cyc    = 0;

  // per-test observations
  int           beat_cnt, stall_cnt;
  int           last_burst, first_burst;
  logic [255:0] cap9, cap0;

  // compare-process state
  bit           prev_stall, prev_hs_last;
  logic [255:0] prev_data;
  logic [5:0]   prev_burst;
  logic         prev_last;
  beat_t        e;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Beat model: whole matrix is a flat sequence of beats numbered from 0.
  task automatic model_tile(input tile_t t, input type_t ty);
    int bpt;
    int total;
    beat_t b;
    bpt   = (ty == TYPE_FP16) ? 4 : 8;
    total = 4 * bpt;
    for (int k = 0; k < bpt; k++) begin
      b.data = '0;
      for (int i = 0; i < 8; i++) begin
        if (ty == TYPE_FP16) begin
          b.data[16*i     +: 16] = t[2*k][i][15:0];
          b.data[16*(i+8) +: 16] = t[2*k+1][i][15:0];
        end else begin
          b.data[32*i +: 32] = t[k][i];
        end
      end
      b.burst = 6'(mdl_idx);
      b.last  = (mdl_idx == total - 1);
      mdl_idx++;
      exp_q.push_back(b);
    end
  endtask

  function automatic tile_t mk_idx(input int t);
    tile_t x;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        x[r][c] = 32'((t << 16) | (r << 8) | c);
    return x;
  endfunction

  function automatic tile_t mk_const(input logic [31:0] v);
    tile_t x;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        x[r][c] = v;
    return x;
  endfunction

  function automatic tile_t mk_mix(input int t);
    tile_t x;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        x[r][c] = 32'((r * 8 + c) * 32'h01010101) ^ 32'(t << 28);
    return x;
  endfunction

  task automatic clr_stats();
    beat_cnt    = 0;
    stall_cnt   = 0;
    last_burst  = -1;
    first_burst = -1;
    cap9        = '0;
    cap0        = '0;
    mdl_idx     = 0;
  endtask

  task automatic send_tile(input tile_t t, input type_t ty_live, input rc_t rc_v,
                           input type_t ty_model, input bit push);
    int n;
    bit ok;
    tile_data  = t;
    data_type  = ty_live;
    rc         = rc_v;
    tile_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (tile_ready) ok = 1'b1;
      n++;
    end
    if (!ok) chk("tile_accept_timeout", 0, 1);
    else if (push) model_tile(t, ty_model);
    @(posedge clk);
    #1 tile_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    @(posedge clk);
    #1;
  endtask

  // sink readiness: held high, or cycling 1,0,0,1
  initial begin
    axi_if.axi_wready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      axi_if.axi_wready = rmode ? rpat[3 - (cyc % 4)] : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst || !chk_en) begin
      prev_stall   = 1'b0;
      prev_hs_last = 1'b0;
    end else begin
      chk("done_pulse", done, prev_hs_last);
      if (axi_if.axi_wvalid) chk("tile_ready_in_send", tile_ready, 0);
      if (prev_stall) begin
        stall_cnt++;
        chk("stall_wvalid", axi_if.axi_wvalid, 1);
        chk("stall_wdata", axi_if.axi_wdata, prev_data);
        chk("stall_burst", axi_if.burst_num, prev_burst);
        chk("stall_wlast", axi_if.axi_wlast, prev_last);
      end
      if (axi_if.axi_wvalid && axi_if.axi_wready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_burst", axi_if.burst_num, 6'h3f);
        end else begin
          e = exp_q.pop_front();
          chk("wdata", axi_if.axi_wdata, e.data);
          chk("burst_num", axi_if.burst_num, e.burst);
          chk("wlast", axi_if.axi_wlast, e.last);
        end
        if (beat_cnt == 0) begin
          first_burst = int'(axi_if.burst_num);
          cap0        = axi_if.axi_wdata;
        end
        beat_cnt++;
        if (axi_if.burst_num == 6'd9) cap9 = axi_if.axi_wdata;
        if (axi_if.axi_wlast) last_burst = int'(axi_if.burst_num);
      end
      prev_stall   = axi_if.axi_wvalid && !axi_if.axi_wready;
      prev_data    = axi_if.axi_wdata;
      prev_burst   = axi_if.burst_num;
      prev_last    = axi_if.axi_wlast;
      prev_hs_last = axi_if.axi_wvalid && axi_if.axi_wready && axi_if.axi_wlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit seen;
    rst        = 1'b1;
    tile_valid = 1'b0;
    tile_data  = '0;
    data_type  = TYPE_FP32;
    rc         = RC_M32N8;
    clr_stats();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wvalid", axi_if.axi_wvalid, 0);
    chk("rst_wlast", axi_if.axi_wlast, 0);
    chk("rst_wdata", axi_if.axi_wdata, 0);
    chk("rst_burst", axi_if.burst_num, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_tile_ready", tile_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // FP32, rc=00, sink always ready
    clr_stats();
    for (int t = 0; t < 4; t++) send_tile(mk_idx(t), TYPE_FP32, RC_M32N8, TYPE_FP32, 1'b1);
    wait_done(200);
    chk("fp32_beats", beat_cnt, 32);
    chk("fp32_last_burst", last_burst, 31);
    chk("fp32_beat9_lane3", cap9[96 +: 32], 32'h00010103);
    chk("fp32_beat9_lane7", cap9[224 +: 32], 32'h00010107);
    chk("fp32_model_empty", exp_q.size(), 0);
    chk("fp32_err", err, 0);

    // FP16, rc=01, upper halves discarded
    clr_stats();
    for (int t = 0; t < 4; t++)
      send_tile(mk_const(32'hABCD_1234), TYPE_FP16, RC_M16N16, TYPE_FP16, 1'b1);
    wait_done(200);
    chk("fp16_beats", beat_cnt, 16);
    chk("fp16_last_burst", last_burst, 15);
    chk("fp16_halfwords", cap0, {16{16'h1234}});
    chk("fp16_model_empty", exp_q.size(), 0);

    // INT8, rc=10, sink stalls
    clr_stats();
    rmode = 1'b1;
    for (int t = 0; t < 4; t++) send_tile(mk_mix(t), TYPE_INT8, RC_M8N32, TYPE_INT8, 1'b1);
    wait_done(400);
    rmode = 1'b0;
    chk("int8_beats", beat_cnt, 32);
    chk("int8_last_burst", last_burst, 31);
    chk("int8_stalls_seen", (stall_cnt > 0), 1);
    chk("int8_model_empty", exp_q.size(), 0);

    // live data_type changes to FP16 mid-matrix; latched FP32 must remain in force
    clr_stats();
    send_tile(mk_idx(4), TYPE_FP32, RC_M32N8, TYPE_FP32, 1'b1);
    for (int t = 5; t < 8; t++) send_tile(mk_idx(t), TYPE_FP16, RC_ILLEGAL, TYPE_FP32, 1'b1);
    wait_done(200);
    chk("latched_type_beats", beat_cnt, 32);
    chk("latched_type_last_burst", last_burst, 31);
    chk("latched_type_model_empty", exp_q.size(), 0);

    // illegal shape on the first tile
    clr_stats();
    send_tile(mk_idx(1), TYPE_FP32, RC_ILLEGAL, TYPE_FP32, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("illegal_err", err, 1);
      chk("illegal_wvalid", axi_if.axi_wvalid, 0);
      chk("illegal_tile_ready", tile_ready, 1);
    end
    chk("illegal_beats", beat_cnt, 0);

    // reset in the middle of an FP32 matrix
    @(posedge clk);
    #1;
    clr_stats();
    send_tile(mk_idx(2), TYPE_FP32, RC_M32N8, TYPE_FP32, 1'b1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      if (axi_if.axi_wvalid && axi_if.axi_wready && axi_if.burst_num == 6'd5) seen = 1'b1;
      n++;
    end
    chk("burst5_seen", seen, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_wvalid", axi_if.axi_wvalid, 0);
    chk("midrst_tile_ready", tile_ready, 1);
    chk("midrst_err_cleared", err, 0);
    chk("midrst_wlast", axi_if.axi_wlast, 0);

    // tile offered together with reset must be dropped
    @(posedge clk);
    #1;
    rst        = 1'b1;
    tile_valid = 1'b1;
    tile_data  = mk_idx(3);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    tile_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_wins_wvalid", axi_if.axi_wvalid, 0);
    end

    @(posedge clk);
    #1;
    clr_stats();
    for (int t = 0; t < 4; t++) send_tile(mk_idx(t + 8), TYPE_FP32, RC_M32N8, TYPE_FP32, 1'b1);
    wait_done(200);
    chk("restart_first_burst", first_burst, 0);
    chk("restart_beats", beat_cnt, 32);
    chk("restart_model_empty", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
